// File: rtl/equiv_mon_pkg.sv
// Shared types and helpers for the multi-channel equivalence monitor.
package equiv_mon_pkg;

    // Per-channel comparison state.
    typedef enum logic [1:0] {
        MATCH  = 2'd0,
        SKEW   = 2'd1,
        FAILED = 2'd2
    } chan_state_e;

    // Comparison policy selected by the mode input.
    typedef enum logic {
        STRICT   = 1'b0,
        WINDOWED = 1'b1
    } eq_mode_e;

    // Widest pulse vector the popcount helper accepts.
    localparam int POP_IN_W  = 64;
    localparam int POP_OUT_W = 7;

    // Number of set bits in a pulse vector.
    // Narrower vectors are zero-extended by the caller.
    function automatic logic [POP_OUT_W-1:0] popcount(input logic [POP_IN_W-1:0] v);
        logic [POP_OUT_W-1:0] c;
        c = '0;
        for (int i = 0; i < POP_IN_W; i++) begin
            c = c + POP_OUT_W'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/equiv_mon_chan.sv
// One compared channel: MATCH/SKEW/FAILED state machine plus skew counter.
// The pass/fail outputs are combinational and describe the sample being
// taken on the coming edge; the top registers them.
module equiv_mon_chan
    import equiv_mon_pkg::*;
#(
    parameter int WIDTH    = 1,
    parameter int MAX_SKEW = 2
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             pass,
    output logic             fail
);

    localparam int SKEW_W = $clog2(MAX_SKEW + 1);
    localparam logic [SKEW_W-1:0] SKEW_LIMIT = SKEW_W'(MAX_SKEW);

    chan_state_e       state_reg, state_next;
    logic [SKEW_W-1:0] skew_reg, skew_next;
    logic              equal;
    logic              windowed;

    assign equal    = (a == b);
    assign windowed = (mode == WINDOWED);

    // State and skew counter; skew progress is discarded on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= MATCH;
            skew_reg  <= '0;
        end else begin
            state_reg <= state_next;
            skew_reg  <= skew_next;
        end
    end

    // Next-state and raw result; nothing moves unless en (clr wins over en).
    always_comb begin
        state_next = state_reg;
        skew_next  = skew_reg;
        pass       = 1'b0;
        fail       = 1'b0;
        if (clr) begin
            state_next = MATCH;
            skew_next  = '0;
        end else if (en) begin
            unique case (state_reg)
                MATCH: begin
                    if (equal) begin
                        pass = 1'b1;
                    end else if (!windowed) begin
                        fail       = 1'b1;
                        state_next = FAILED;
                    end else begin
                        state_next = SKEW;
                        skew_next  = SKEW_W'(1);
                    end
                end
                SKEW: begin
                    if (equal) begin
                        pass       = 1'b1;
                        state_next = MATCH;
                        skew_next  = '0;
                    end else if (!windowed || skew_reg >= SKEW_LIMIT) begin
                        // A switch to strict while skewing fails at once.
                        fail       = 1'b1;
                        state_next = FAILED;
                        skew_next  = '0;
                    end else begin
                        skew_next = skew_reg + SKEW_W'(1);
                    end
                end
                FAILED: begin
                    if (equal) begin
                        pass       = 1'b1;
                        state_next = MATCH;
                        skew_next  = '0;
                    end else begin
                        fail = 1'b1;
                    end
                end
                default: begin
                    state_next = MATCH;
                    skew_next  = '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/equiv_monitor.sv
// Multi-channel equivalence monitor: per-channel checkers, registered
// pulses, saturating pass/fail counters, sticky error and first-fail capture.
module equiv_monitor
    import equiv_mon_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int WIDTH    = 1,
    parameter int MAX_SKEW = 2,
    parameter int CNT_W    = 16,
    parameter int CYC_W    = 32,
    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
)(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    clr,
    input  logic                    mode,
    input  logic [NUM_CH*WIDTH-1:0] sig_a,
    input  logic [NUM_CH*WIDTH-1:0] sig_b,
    output logic [NUM_CH-1:0]       pass_pulse,
    output logic [NUM_CH-1:0]       fail_pulse,
    output logic [CNT_W-1:0]        pass_cnt,
    output logic [CNT_W-1:0]        fail_cnt,
    output logic                    err_sticky,
    output logic                    first_fail_vld,
    output logic [CH_W-1:0]         first_fail_ch,
    output logic [CYC_W-1:0]        first_fail_cyc
);

    // Sum width leaves headroom for a full popcount on top of a full counter.
    localparam int SUM_W = CNT_W + POP_OUT_W + 1;
    localparam logic [SUM_W-1:0] CNT_SAT = {{(POP_OUT_W + 1){1'b0}}, {CNT_W{1'b1}}};

    logic [NUM_CH-1:0] raw_pass;
    logic [NUM_CH-1:0] raw_fail;

    logic [NUM_CH-1:0] pass_pulse_reg, pass_pulse_next;
    logic [NUM_CH-1:0] fail_pulse_reg, fail_pulse_next;
    logic [CNT_W-1:0]  pass_cnt_reg, pass_cnt_next;
    logic [CNT_W-1:0]  fail_cnt_reg, fail_cnt_next;
    logic              err_sticky_reg, err_sticky_next;
    logic              ff_vld_reg, ff_vld_next;
    logic [CH_W-1:0]   ff_ch_reg, ff_ch_next;
    logic [CYC_W-1:0]  ff_cyc_reg, ff_cyc_next;
    logic [CYC_W-1:0]  cyc_cnt_reg, cyc_cnt_next;

    logic [POP_OUT_W-1:0] pass_pop;
    logic [POP_OUT_W-1:0] fail_pop;
    logic [SUM_W-1:0]     pass_sum;
    logic [SUM_W-1:0]     fail_sum;
    logic [CH_W-1:0]      lowest_fail;

    // One checker per channel pair.
    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
            equiv_mon_chan #(
                .WIDTH    (WIDTH),
                .MAX_SKEW (MAX_SKEW)
            ) u_chan (
                .clk   (clk),
                .rst_n (rst_n),
                .en    (en),
                .clr   (clr),
                .mode  (mode),
                .a     (sig_a[gi*WIDTH +: WIDTH]),
                .b     (sig_b[gi*WIDTH +: WIDTH]),
                .pass  (raw_pass[gi]),
                .fail  (raw_fail[gi])
            );
        end
    endgenerate

    // Pulse vectors wider than the popcount helper are not supported.
    assign pass_pop = popcount(POP_IN_W'(raw_pass));
    assign fail_pop = popcount(POP_IN_W'(raw_fail));
    assign pass_sum = SUM_W'(pass_cnt_reg) + SUM_W'(pass_pop);
    assign fail_sum = SUM_W'(fail_cnt_reg) + SUM_W'(fail_pop);

    // Lowest failing channel index wins on simultaneous fails.
    always_comb begin
        lowest_fail = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (raw_fail[i]) begin
                lowest_fail = CH_W'(i);
            end
        end
    end

    // Aggregation: counters move together with the pulses they count.
    always_comb begin
        pass_pulse_next = raw_pass;
        fail_pulse_next = raw_fail;
        pass_cnt_next   = pass_cnt_reg;
        fail_cnt_next   = fail_cnt_reg;
        err_sticky_next = err_sticky_reg;
        ff_vld_next     = ff_vld_reg;
        ff_ch_next      = ff_ch_reg;
        ff_cyc_next     = ff_cyc_reg;
        cyc_cnt_next    = cyc_cnt_reg;
        if (clr) begin
            pass_pulse_next = '0;
            fail_pulse_next = '0;
            pass_cnt_next   = '0;
            fail_cnt_next   = '0;
            err_sticky_next = 1'b0;
            ff_vld_next     = 1'b0;
            ff_ch_next      = '0;
            ff_cyc_next     = '0;
            cyc_cnt_next    = '0;
        end else if (en) begin
            pass_cnt_next = (pass_sum > CNT_SAT) ? {CNT_W{1'b1}} : pass_sum[CNT_W-1:0];
            fail_cnt_next = (fail_sum > CNT_SAT) ? {CNT_W{1'b1}} : fail_sum[CNT_W-1:0];
            if (|raw_fail) begin
                err_sticky_next = 1'b1;
                if (!ff_vld_reg) begin
                    ff_vld_next = 1'b1;
                    ff_ch_next  = lowest_fail;
                    ff_cyc_next = cyc_cnt_reg;
                end
            end
            cyc_cnt_next = cyc_cnt_reg + CYC_W'(1);
        end
    end

    // Output and bookkeeping registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass_pulse_reg <= '0;
            fail_pulse_reg <= '0;
            pass_cnt_reg   <= '0;
            fail_cnt_reg   <= '0;
            err_sticky_reg <= 1'b0;
            ff_vld_reg     <= 1'b0;
            ff_ch_reg      <= '0;
            ff_cyc_reg     <= '0;
            cyc_cnt_reg    <= '0;
        end else begin
            pass_pulse_reg <= pass_pulse_next;
            fail_pulse_reg <= fail_pulse_next;
            pass_cnt_reg   <= pass_cnt_next;
            fail_cnt_reg   <= fail_cnt_next;
            err_sticky_reg <= err_sticky_next;
            ff_vld_reg     <= ff_vld_next;
            ff_ch_reg      <= ff_ch_next;
            ff_cyc_reg     <= ff_cyc_next;
            cyc_cnt_reg    <= cyc_cnt_next;
        end
    end

    assign pass_pulse     = pass_pulse_reg;
    assign fail_pulse     = fail_pulse_reg;
    assign pass_cnt       = pass_cnt_reg;
    assign fail_cnt       = fail_cnt_reg;
    assign err_sticky     = err_sticky_reg;
    assign first_fail_vld = ff_vld_reg;
    assign first_fail_ch  = ff_ch_reg;
    assign first_fail_cyc = ff_cyc_reg;

endmodule

// File: tb/tb_equiv_monitor.sv
// Scoreboard bench for equiv_monitor: a 1-channel instance with 3-bit
// counters and a 4-channel instance with 16-bit counters share control.
module tb_equiv_monitor;

    localparam int MAX_SKEW = 2;
    localparam int S_MATCH  = 0;
    localparam int S_SKEW   = 1;
    localparam int S_FAIL   = 2;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        clr;
    logic        mode;
    logic        sig_a1, sig_b1;
    logic [3:0]  sig_a4, sig_b4;

    logic        pass_pulse1, fail_pulse1;
    logic [2:0]  pass_cnt1, fail_cnt1;
    logic        err_sticky1, first_fail_vld1;
    logic        first_fail_ch1;
    logic [31:0] first_fail_cyc1;

    logic [3:0]  pass_pulse4, fail_pulse4;
    logic [15:0] pass_cnt4, fail_cnt4;
    logic        err_sticky4, first_fail_vld4;
    logic [1:0]  first_fail_ch4;
    logic [31:0] first_fail_cyc4;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc_no = 0;

    equiv_monitor #(.NUM_CH(1), .WIDTH(1), .MAX_SKEW(MAX_SKEW), .CNT_W(3), .CYC_W(32)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .mode(mode),
        .sig_a(sig_a1), .sig_b(sig_b1),
        .pass_pulse(pass_pulse1), .fail_pulse(fail_pulse1),
        .pass_cnt(pass_cnt1), .fail_cnt(fail_cnt1), .err_sticky(err_sticky1),
        .first_fail_vld(first_fail_vld1), .first_fail_ch(first_fail_ch1),
        .first_fail_cyc(first_fail_cyc1)
    );

    equiv_monitor #(.NUM_CH(4), .WIDTH(1), .MAX_SKEW(MAX_SKEW), .CNT_W(16), .CYC_W(32)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .mode(mode),
        .sig_a(sig_a4), .sig_b(sig_b4),
        .pass_pulse(pass_pulse4), .fail_pulse(fail_pulse4),
        .pass_cnt(pass_cnt4), .fail_cnt(fail_cnt4), .err_sticky(err_sticky4),
        .first_fail_vld(first_fail_vld4), .first_fail_ch(first_fail_ch4),
        .first_fail_cyc(first_fail_cyc4)
    );

    initial begin
        clk = 1'b0;
        forever #2 clk = ~clk;
    end

    typedef struct {
        logic [3:0]  pp;
        logic [3:0]  fp;
        int          pc;
        int          fc;
        bit          err;
        bit          vld;
        int          fch;
        int unsigned fcyc;
    } exp_t;

    exp_t q1[$];
    exp_t q4[$];

    // Reference state, index 0 = 1-channel instance, 1 = 4-channel instance.
    int          st[2][4];
    int          sk[2][4];
    int unsigned cyc[2];
    int          pc[2];
    int          fc[2];
    bit          err[2];
    bit          vld[2];
    int          fch[2];
    int unsigned fcyc[2];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc_no);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 4; i++) begin
                st[d][i] = S_MATCH;
                sk[d][i] = 0;
            end
            cyc[d] = 0; pc[d] = 0; fc[d] = 0; err[d] = 0; vld[d] = 0; fch[d] = 0; fcyc[d] = 0;
        end
        q1.delete();
        q4.delete();
    endtask

    // Expected outputs after the edge that samples the given inputs.
    task automatic model_step(input int d, input bit c, input bit e, input bit m,
                              input logic [3:0] a, input logic [3:0] b, output exp_t x);
        int n;
        int smax;
        int np;
        int nf;
        logic [3:0] pp;
        logic [3:0] fp;
        n = (d == 0) ? 1 : 4;
        smax = (d == 0) ? 7 : 65535;
        np = 0; nf = 0; pp = 4'b0; fp = 4'b0;
        if (c) begin
            for (int i = 0; i < 4; i++) begin
                st[d][i] = S_MATCH;
                sk[d][i] = 0;
            end
            cyc[d] = 0; pc[d] = 0; fc[d] = 0; err[d] = 0; vld[d] = 0; fch[d] = 0; fcyc[d] = 0;
        end else if (e) begin
            for (int i = 0; i < n; i++) begin
                if (a[i] == b[i]) begin
                    pp[i] = 1'b1;
                    st[d][i] = S_MATCH;
                    sk[d][i] = 0;
                end else if (st[d][i] == S_MATCH) begin
                    if (m) begin
                        st[d][i] = S_SKEW;
                        sk[d][i] = 1;
                    end else begin
                        fp[i] = 1'b1;
                        st[d][i] = S_FAIL;
                    end
                end else if (st[d][i] == S_SKEW) begin
                    if (!m || sk[d][i] >= MAX_SKEW) begin
                        fp[i] = 1'b1;
                        st[d][i] = S_FAIL;
                        sk[d][i] = 0;
                    end else begin
                        sk[d][i]++;
                    end
                end else begin
                    fp[i] = 1'b1;
                end
                np += int'(pp[i]);
                nf += int'(fp[i]);
            end
            pc[d] = (pc[d] + np > smax) ? smax : pc[d] + np;
            fc[d] = (fc[d] + nf > smax) ? smax : fc[d] + nf;
            if (nf > 0) begin
                err[d] = 1'b1;
                if (!vld[d]) begin
                    vld[d] = 1'b1;
                    fcyc[d] = cyc[d];
                    for (int i = n - 1; i >= 0; i--) begin
                        if (fp[i]) fch[d] = i;
                    end
                end
            end
            cyc[d]++;
        end
        x.pp = pp; x.fp = fp; x.pc = pc[d]; x.fc = fc[d]; x.err = err[d];
        x.vld = vld[d]; x.fch = fch[d]; x.fcyc = fcyc[d];
    endtask

    // Drive one sample, push expectations, then pop and compare after the edge.
    task automatic cycle(input bit c, input bit e, input bit m, input logic a1, input logic b1,
                         input logic [3:0] a4, input logic [3:0] b4);
        exp_t x1;
        exp_t x4;
        clr = c; en = e; mode = m;
        sig_a1 = a1; sig_b1 = b1; sig_a4 = a4; sig_b4 = b4;
        model_step(0, c, e, m, {3'b0, a1}, {3'b0, b1}, x1);
        q1.push_back(x1);
        model_step(1, c, e, m, a4, b4, x4);
        q4.push_back(x4);
        @(posedge clk);
        #1;
        cyc_no++;
        x1 = q1.pop_front();
        x4 = q4.pop_front();
        chk("d1_pass_pulse", 64'(pass_pulse1), 64'(x1.pp[0]));
        chk("d1_fail_pulse", 64'(fail_pulse1), 64'(x1.fp[0]));
        chk("d1_pass_cnt", 64'(pass_cnt1), 64'(x1.pc));
        chk("d1_fail_cnt", 64'(fail_cnt1), 64'(x1.fc));
        chk("d1_err_sticky", 64'(err_sticky1), 64'(x1.err));
        chk("d1_ff_vld", 64'(first_fail_vld1), 64'(x1.vld));
        chk("d1_ff_ch", 64'(first_fail_ch1), 64'(x1.fch));
        chk("d1_ff_cyc", 64'(first_fail_cyc1), 64'(x1.fcyc));
        chk("d4_pass_pulse", 64'(pass_pulse4), 64'(x4.pp));
        chk("d4_fail_pulse", 64'(fail_pulse4), 64'(x4.fp));
        chk("d4_pass_cnt", 64'(pass_cnt4), 64'(x4.pc));
        chk("d4_fail_cnt", 64'(fail_cnt4), 64'(x4.fc));
        chk("d4_err_sticky", 64'(err_sticky4), 64'(x4.err));
        chk("d4_ff_vld", 64'(first_fail_vld4), 64'(x4.vld));
        chk("d4_ff_ch", 64'(first_fail_ch4), 64'(x4.fch));
        chk("d4_ff_cyc", 64'(first_fail_cyc4), 64'(x4.fcyc));
        $display("[TB] cyc %0d clr=%0d en=%0d mode=%0d d1 a/b=%0b%0b pp=%0b fp=%0b | d4 a=%4b b=%4b pp=%4b fp=%4b pc=%0d fc=%0d",
                 cyc_no, c, e, m, a1, b1, pass_pulse1, fail_pulse1, a4, b4,
                 pass_pulse4, fail_pulse4, pass_cnt4, fail_cnt4);
    endtask

    task automatic chk_all_zero(input string tag);
        logic [63:0] acc;
        acc = 64'(pass_pulse1) | 64'(fail_pulse1) | 64'(pass_cnt1) | 64'(fail_cnt1)
            | 64'(err_sticky1) | 64'(first_fail_vld1) | 64'(first_fail_ch1) | 64'(first_fail_cyc1);
        chk({tag, "_d1"}, acc, 64'd0);
        acc = 64'(pass_pulse4) | 64'(fail_pulse4) | 64'(pass_cnt4) | 64'(fail_cnt4)
            | 64'(err_sticky4) | 64'(first_fail_vld4) | 64'(first_fail_ch4) | 64'(first_fail_cyc4);
        chk({tag, "_d4"}, acc, 64'd0);
    endtask

    initial begin
        bit [0:5] t1a;
        bit [0:5] t1b;
        logic [3:0] ra;
        logic [3:0] rb;
        t1a = 6'b001111;
        t1b = 6'b000011;

        rst_n = 1'b0; clr = 1'b0; en = 1'b0; mode = 1'b0;
        sig_a1 = 1'b0; sig_b1 = 1'b0; sig_a4 = 4'h0; sig_b4 = 4'h0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst_n = 1'b1;

        // Strict single-channel sequence 00,00,10,10,11,11.
        for (int i = 0; i < 6; i++) cycle(0, 1, 0, t1a[i], t1b[i], 4'h0, 4'h0);
        chk("t1_pass_cnt", 64'(pass_cnt1), 64'd4);
        chk("t1_fail_cnt", 64'(fail_cnt1), 64'd2);
        chk("t1_ff_cyc", 64'(first_fail_cyc1), 64'd2);

        // Windowed: two-sample mismatch tolerated, three-sample mismatch fails.
        cycle(1, 1, 1, 0, 0, 4'h0, 4'h0);
        cycle(0, 1, 1, 0, 0, 4'b0001, 4'h0);
        cycle(0, 1, 1, 0, 0, 4'b0001, 4'h0);
        cycle(0, 1, 1, 0, 0, 4'h0, 4'h0);
        chk("t2_err_clean", 64'(err_sticky4), 64'd0);
        for (int i = 0; i < 5; i++) begin
            cycle(0, 1, 1, 0, 0, 4'b0100, 4'h0);
            chk("t2_skew_fail", 64'(fail_pulse4), (i >= 2) ? 64'h4 : 64'h0);
        end
        cycle(0, 1, 1, 0, 0, 4'h0, 4'h0);
        // Mode switched to strict while skewing fails immediately.
        cycle(0, 1, 1, 0, 0, 4'b0010, 4'h0);
        cycle(0, 1, 0, 0, 0, 4'b0010, 4'h0);
        chk("t2_mode_switch", 64'(fail_pulse4), 64'h2);
        cycle(0, 1, 0, 0, 0, 4'h0, 4'h0);

        // Simultaneous fails: lowest index captured, later fails ignored.
        cycle(1, 1, 0, 0, 0, 4'h0, 4'h0);
        cycle(0, 1, 0, 0, 0, 4'b1010, 4'h0);
        chk("t3_fail_pulse", 64'(fail_pulse4), 64'ha);
        chk("t3_fail_cnt", 64'(fail_cnt4), 64'd2);
        chk("t3_ff_ch", 64'(first_fail_ch4), 64'd1);
        cycle(0, 1, 0, 0, 0, 4'h0, 4'h0);
        cycle(0, 1, 0, 0, 0, 4'b0001, 4'h0);
        chk("t3_ff_ch_frozen", 64'(first_fail_ch4), 64'd1);
        cycle(0, 1, 0, 0, 0, 4'h0, 4'h0);

        // Saturation of the 3-bit counter, then clear with en high.
        for (int i = 0; i < 10; i++) cycle(0, 1, 0, 1, 0, 4'h0, 4'h0);
        chk("t4_fail_sat", 64'(fail_cnt1), 64'd7);
        cycle(1, 1, 0, 1, 0, 4'h0, 4'h0);
        chk("t4_clr_pass", 64'(pass_cnt1), 64'd0);
        chk("t4_clr_fail", 64'(fail_cnt1), 64'd0);
        chk("t4_clr_err", 64'(err_sticky1), 64'd0);
        chk("t4_clr_vld", 64'(first_fail_vld1), 64'd0);
        cycle(0, 1, 0, 0, 0, 4'h0, 4'h0);

        // Enable low mid-skew: state and cycle count hold.
        cycle(1, 1, 1, 0, 0, 4'h0, 4'h0);
        cycle(0, 1, 1, 0, 0, 4'b0001, 4'h0);
        for (int i = 0; i < 5; i++) begin
            cycle(0, 0, 1, 0, 0, 4'b0001, 4'h0);
            chk("t5_frozen_pulse", 64'(fail_pulse4), 64'h0);
        end
        cycle(0, 1, 1, 0, 0, 4'b0001, 4'h0);
        chk("t5_resume_nofail", 64'(fail_pulse4), 64'h0);
        cycle(0, 1, 1, 0, 0, 4'b0001, 4'h0);
        chk("t5_resume_fail", 64'(fail_pulse4), 64'h1);
        chk("t5_ff_cyc", 64'(first_fail_cyc4), 64'd2);
        cycle(0, 1, 1, 0, 0, 4'h0, 4'h0);

        // Random traffic, mostly-equal buses, occasional clr / en low.
        for (int i = 0; i < 60; i++) begin
            ra = 4'($urandom);
            rb = ra ^ (4'($urandom) & 4'($urandom));
            cycle($urandom_range(0, 15) == 0, $urandom_range(0, 7) != 0, 1'($urandom),
                  1'($urandom), 1'($urandom), ra, rb);
        end

        // Asynchronous reset while channels sit in FAILED.
        cycle(0, 1, 0, 1, 0, 4'b1000, 4'h0);
        cycle(0, 1, 0, 1, 0, 4'b1000, 4'h0);
        #1;
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_rst");
        model_reset();
        rst_n = 1'b1;
        cycle(0, 1, 0, 0, 0, 4'h0, 4'h0);
        chk("t6_pass_after_rst", 64'(pass_pulse4), 64'hf);
        chk("t6_fail_after_rst", 64'(fail_pulse4), 64'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
